tdm_demux_1x16: RTL and testbench
=================================

# tdm_demux_1x16

Time-division demultiplexer that receives a 1-bit serial stream carrying 16 time-multiplexed channels, one bit per channel per frame, and rebuilds the 16-bit parallel word. It is the receive-side counterpart of the 16:1 channel multiplexer: the transmitter walks its select index 0..15 over the line, and this block walks a matching channel index, storing each bit in its slot. It sits between the serial link and any parallel consumer, and presents one registered word plus a one-cycle strobe per completed frame.

## Interface
- N, 16, channels per frame; must equal 2**SELW
- SELW, 4, channel index width
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- din  input  1  serial data bit for the current channel slot
- din_valid  input  1  din is valid this cycle; beat accepted on clk edge when high
- sof  input  1  start of frame; qualified by din_valid; marks the channel-0 beat
- dout  output  N  last completed frame; dout[k] = bit received in channel slot k
- frame_valid  output  1  one-cycle pulse, high in the cycle dout is updated
- frame_err  output  1  one-cycle pulse when a frame is aborted by an early sof
- ch_idx  output  SELW  channel slot the next accepted beat will be written to
- busy  output  1  high while a frame is in progress (state RECV)

## Operation
- Internal shadow register sh[N-1:0], channel counter, two-state FSM: IDLE, RECV.
- IDLE: beats without sof are ignored. On din_valid & sof: sh[0] <= din, ch_idx <= 1, go to RECV.
- RECV, din_valid & ~sof: sh[ch_idx] <= din, ch_idx increments.
  - If ch_idx == N-1: dout <= {din, sh[N-2:0]}, frame_valid pulses, ch_idx <= 0, go to IDLE.
- RECV, din_valid & sof (any ch_idx, including N-1): frame_err pulses, the partial frame is discarded, dout is unchanged, and this beat starts a new frame (sh[0] <= din, ch_idx <= 1, stay in RECV).
- din_valid low: no state change. Gaps of any length are allowed mid-frame.
- Bits of sh not yet written in the current frame never reach dout. A frame completes only after all N slots have been written.
- ch_idx wraps N-1 -> 0 only on frame completion and never counts past N-1.
- busy = (state == RECV).

## Timing
- Reset (rst_n low, asynchronous) values:
  - dout = 0, sh = 0, frame_valid = 0, frame_err = 0, ch_idx = 0, busy = 0, state IDLE.
  - Asserting reset mid-frame discards the partial frame, with no strobe.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Latency: the last beat (slot N-1) is sampled at edge E. dout and frame_valid change after E and are visible for exactly the one cycle following E. dout holds until the next completion.
- Minimum frame time is N consecutive valid cycles. Back-to-back frames with zero gap are supported: the sof beat in the cycle after completion is accepted from IDLE.
- frame_valid and frame_err are never high in the same cycle.

## Test plan
- Reset: hold rst_n low, drive din = 1, din_valid = 1 -> all outputs 0. Release rst_n without sof -> busy stays 0 and ch_idx stays 0.
- Single frame: send 16 consecutive beats, sof on the first, bits for slots 0..15 = 1,0,1,1,0,0,0,0,0,0,0,0,0,0,0,1 -> one-cycle frame_valid after the 16th beat, dout = 16'h800D, ch_idx = 0, busy = 0.
- Gapped frame: the same data as the single-frame test with din_valid low for 3 cycles after slots 4 and 11 -> ch_idx holds during the gaps, dout = 16'h800D, frame_valid is issued exactly once.
- Early sof abort: start a frame and write slots 0..6, then a sof beat with din = 1 followed by 15 beats of 0 -> frame_err pulses at the abort, then frame_valid with dout = 16'h0001. No frame_valid for the aborted frame.
- Back-to-back: frame A = 16'hA5A5, then frame B = 16'h5A5A with zero idle cycles -> two frame_valid pulses 16 cycles apart, with dout = 16'hA5A5 then 16'h5A5A.
- Reset mid-frame: after 9 beats pull rst_n low for 1 cycle, then send full frame 16'hFFFF -> no strobe for the partial frame, and dout goes 0 -> 16'hFFFF.

Source files
------------

// File: rtl/tdm_demux_1x16_if.sv
// Serial TDM receive bus: one bit per channel slot in, rebuilt parallel frame out.
interface tdm_demux_1x16_if #(
  parameter int N    = 16,
  parameter int SELW = 4
);
  logic            din;
  logic            din_valid;
  logic            sof;
  logic [N-1:0]    dout;
  logic            frame_valid;
  logic            frame_err;
  logic [SELW-1:0] ch_idx;
  logic            busy;

  modport master (
    output din, din_valid, sof,
    input  dout, frame_valid, frame_err, ch_idx, busy
  );

  modport slave (
    input  din, din_valid, sof,
    output dout, frame_valid, frame_err, ch_idx, busy
  );
endinterface

// File: rtl/tdm_demux_1x16.sv
// 1-bit TDM stream to 16-bit parallel word; one registered word and strobe per frame.

module tdm_demux_1x16_slot (
  input  logic clk,
  input  logic rst_n,
  input  logic we,
  input  logic d,
  output logic q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)  q <= 1'b0;
    else if (we) q <= d;
endmodule

module tdm_demux_1x16 #(
  parameter int N    = 16,
  parameter int SELW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  tdm_demux_1x16_if.slave   bus
);
  typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

  state_t          st, nxt;
  logic [SELW-1:0] ch_q;
  logic [N-1:0]    dout_q;
  logic            fv_q, fe_q;
  logic            sof_beat, data_beat, done, abort;
  logic            last_slot;

  // Slot N-1 goes straight from din into dout, so only N-1 slots need storage.
  logic [N-2:0]    sh;
  logic [N-2:0]    sh_we;

  assign last_slot = (ch_q == SELW'(N-1));

  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else        st <= nxt;

  // Next-state logic
  always_comb begin
    nxt = st;
    case (st)
      IDLE:    if (bus.din_valid && bus.sof) nxt = RECV;
      RECV:    if (bus.din_valid && !bus.sof && last_slot) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Output/control decode; a sof beat always restarts, aborting any frame in flight
  always_comb begin
    sof_beat  = bus.din_valid & bus.sof;
    data_beat = 1'b0;
    abort     = 1'b0;
    if (st == RECV) begin
      data_beat = bus.din_valid & ~bus.sof;
      abort     = sof_beat;
    end
    done = data_beat & last_slot;
  end

  for (genvar k = 0; k < N-1; k++) begin : g_slot
    if (k == 0) begin : g_first
      assign sh_we[k] = sof_beat | (data_beat & (ch_q == SELW'(k)));
    end else begin : g_rest
      assign sh_we[k] = data_beat & (ch_q == SELW'(k));
    end
    tdm_demux_1x16_slot u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (sh_we[k]),
      .d     (bus.din),
      .q     (sh[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ch_q   <= '0;
      dout_q <= '0;
      fv_q   <= 1'b0;
      fe_q   <= 1'b0;
    end else begin
      fv_q <= done;
      fe_q <= abort;
      if (sof_beat)       ch_q <= SELW'(1);
      else if (done)      ch_q <= '0;
      else if (data_beat) ch_q <= ch_q + SELW'(1);
      if (done) dout_q <= {bus.din, sh};
    end

  assign bus.dout        = dout_q;
  assign bus.frame_valid = fv_q;
  assign bus.frame_err   = fe_q;
  assign bus.ch_idx      = ch_q;
  assign bus.busy        = (st == RECV);
endmodule

// File: tb/tb_tdm_demux_1x16.sv
// Directed bench for tdm_demux_1x16: reset, single/gapped frames, abort, back-to-back, mid-frame reset.
module tb_tdm_demux_1x16;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  tdm_demux_1x16_if #(.N(16), .SELW(4)) bus ();

  tdm_demux_1x16 #(.N(16), .SELW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Present one beat, let it be sampled, then settle just past the edge.
  task automatic beat(input logic d, input logic v, input logic s);
    bus.din = d; bus.din_valid = v; bus.sof = s;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; bus.din = 1'b1; bus.din_valid = 1'b1; bus.sof = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.dout !== 16'h0000) begin n_err++; $display("FAIL reset_dout: got %h want 0000", bus.dout); end
    n_cmp++; if (bus.frame_valid !== 1'b0 || bus.frame_err !== 1'b0) begin n_err++; $display("FAIL reset_strobes: got fv=%b fe=%b want 0 0", bus.frame_valid, bus.frame_err); end
    n_cmp++; if (bus.ch_idx !== 4'd0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_ctl: got ch=%0d busy=%b want 0 0", bus.ch_idx, bus.busy); end
    bus.sof = 1'b0;
    rst_n = 1'b1;
    repeat (3) beat(1'b1, 1'b1, 1'b0);
    n_cmp++; if (bus.ch_idx !== 4'd0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_nosof: got ch=%0d busy=%b want 0 0", bus.ch_idx, bus.busy); end
    n_cmp++; if (bus.frame_valid !== 1'b0 || bus.dout !== 16'h0000) begin n_err++; $display("FAIL reset_nosof_out: got fv=%b dout=%h want 0 0000", bus.frame_valid, bus.dout); end
  endtask

  task automatic test_single;
    logic [15:0] w;
    int fv;
    w = 16'h800D; fv = 0;
    for (int i = 0; i < 16; i++) begin
      beat(w[i], 1'b1, i == 0);
      if (i < 15 && bus.frame_valid) fv++;
    end
    n_cmp++; if (fv !== 0) begin n_err++; $display("FAIL single_early_fv: got %0d early strobes want 0", fv); end
    n_cmp++; if (bus.frame_valid !== 1'b1) begin n_err++; $display("FAIL single_fv: got %b want 1", bus.frame_valid); end
    n_cmp++; if (bus.dout !== 16'h800D) begin n_err++; $display("FAIL single_dout: got %h want 800d", bus.dout); end
    n_cmp++; if (bus.ch_idx !== 4'd0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL single_ctl: got ch=%0d busy=%b want 0 0", bus.ch_idx, bus.busy); end
    beat(1'b0, 1'b0, 1'b0);
    n_cmp++; if (bus.frame_valid !== 1'b0) begin n_err++; $display("FAIL single_pulse_width: got fv=%b want 0", bus.frame_valid); end
    n_cmp++; if (bus.dout !== 16'h800D) begin n_err++; $display("FAIL single_hold: got %h want 800d", bus.dout); end
  endtask

  task automatic test_gapped;
    logic [15:0] w;
    int fv, bad_hold;
    w = 16'h800D; fv = 0; bad_hold = 0;
    for (int i = 0; i < 16; i++) begin
      beat(w[i], 1'b1, i == 0);
      if (bus.frame_valid) fv++;
      if (i == 4 || i == 11) begin
        repeat (3) begin
          beat(1'b1, 1'b0, 1'b0);
          if (bus.ch_idx !== 4'(i + 1)) bad_hold++;
          if (bus.frame_valid) fv++;
        end
      end
    end
    n_cmp++; if (bad_hold !== 0) begin n_err++; $display("FAIL gap_ch_hold: got %0d gap cycles with moved ch_idx want 0", bad_hold); end
    n_cmp++; if (bus.dout !== 16'h800D) begin n_err++; $display("FAIL gap_dout: got %h want 800d", bus.dout); end
    beat(1'b0, 1'b0, 1'b0);
    if (bus.frame_valid) fv++;
    n_cmp++; if (fv !== 1) begin n_err++; $display("FAIL gap_fv_count: got %0d want 1", fv); end
  endtask

  task automatic test_abort;
    int fv, fe;
    fv = 0; fe = 0;
    for (int i = 0; i < 7; i++) begin
      beat(1'b1, 1'b1, i == 0);
      if (bus.frame_valid) fv++;
      if (bus.frame_err) fe++;
    end
    beat(1'b1, 1'b1, 1'b1);
    n_cmp++; if (bus.frame_err !== 1'b1 || bus.frame_valid !== 1'b0) begin n_err++; $display("FAIL abort_fe: got fe=%b fv=%b want 1 0", bus.frame_err, bus.frame_valid); end
    n_cmp++; if (bus.ch_idx !== 4'd1 || bus.busy !== 1'b1) begin n_err++; $display("FAIL abort_restart: got ch=%0d busy=%b want 1 1", bus.ch_idx, bus.busy); end
    n_cmp++; if (bus.dout !== 16'h800D) begin n_err++; $display("FAIL abort_dout_kept: got %h want 800d", bus.dout); end
    fe++;
    for (int i = 1; i < 16; i++) begin
      beat(1'b0, 1'b1, 1'b0);
      if (bus.frame_valid) fv++;
      if (bus.frame_err) fe++;
    end
    n_cmp++; if (bus.frame_valid !== 1'b1 || bus.dout !== 16'h0001) begin n_err++; $display("FAIL abort_newframe: got fv=%b dout=%h want 1 0001", bus.frame_valid, bus.dout); end
    n_cmp++; if (fv !== 1 || fe !== 1) begin n_err++; $display("FAIL abort_counts: got fv=%0d fe=%0d want 1 1", fv, fe); end
    beat(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    logic [15:0] wa, wb;
    int c0, c1, fv;
    logic [15:0] d0, d1;
    wa = 16'hA5A5; wb = 16'h5A5A; fv = 0; c0 = -1; c1 = -1; d0 = '0; d1 = '0;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 16; i++) begin
        beat(f == 0 ? wa[i] : wb[i], 1'b1, i == 0);
        if (bus.frame_valid) begin
          if (fv == 0) begin c0 = cyc; d0 = bus.dout; end
          else         begin c1 = cyc; d1 = bus.dout; end
          fv++;
        end
      end
    end
    beat(1'b0, 1'b0, 1'b0);
    if (bus.frame_valid) fv++;
    n_cmp++; if (fv !== 2) begin n_err++; $display("FAIL b2b_count: got %0d want 2", fv); end
    n_cmp++; if (d0 !== 16'hA5A5) begin n_err++; $display("FAIL b2b_dout_a: got %h want a5a5", d0); end
    n_cmp++; if (d1 !== 16'h5A5A) begin n_err++; $display("FAIL b2b_dout_b: got %h want 5a5a", d1); end
    n_cmp++; if (c1 - c0 !== 16) begin n_err++; $display("FAIL b2b_spacing: got %0d cycles want 16", c1 - c0); end
  endtask

  task automatic test_reset_midframe;
    int fv;
    fv = 0;
    for (int i = 0; i < 9; i++) begin
      beat(1'b1, 1'b1, i == 0);
      if (bus.frame_valid) fv++;
    end
    bus.din_valid = 1'b0; bus.sof = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.dout !== 16'h0000 || bus.busy !== 1'b0 || bus.ch_idx !== 4'd0) begin n_err++; $display("FAIL midrst_clear: got dout=%h busy=%b ch=%0d want 0000 0 0", bus.dout, bus.busy, bus.ch_idx); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      beat(1'b1, 1'b1, i == 0);
      if (i < 15 && bus.frame_valid) fv++;
    end
    n_cmp++; if (fv !== 0) begin n_err++; $display("FAIL midrst_spurious: got %0d strobes want 0", fv); end
    n_cmp++; if (bus.frame_valid !== 1'b1 || bus.dout !== 16'hFFFF) begin n_err++; $display("FAIL midrst_frame: got fv=%b dout=%h want 1 ffff", bus.frame_valid, bus.dout); end
    beat(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.din = 1'b0; bus.din_valid = 1'b0; bus.sof = 1'b0;
    test_reset;
    test_single;
    test_gapped;
    test_abort;
    test_back_to_back;
    test_reset_midframe;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
